// File: rtl/alu_issue_unit.sv
// MIPS decode/issue stage that owns the register file and a per-register pending scoreboard.
// Optional feature macro ALU_ISSUE_BYPASS_EN forwards same-cycle writeback data to the sources.
module alu_issue_unit #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [11:0]            out_control,
    output logic [DATA_W-1:0]      out_src1,
    output logic [DATA_W-1:0]      out_src2,
    output logic [4:0]             out_dest,
    input  logic                   wb_en,
    input  logic [4:0]             wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25, FN_SLT = 6'h2A;

    logic [DATA_W-1:0] regfile [32];
    logic [31:0]       scoreboard;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, dest;
    logic [15:0]       imm;
    logic              unused_shamt;
    logic              is_rtype, legal, sign_ext;
    logic              rs_pending, rt_pending, dest_pending, hazard, accept;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
    logic [31:0]       wb_clear, sb_set;

    assign opcode       = in_instr[31:26];
    assign rs           = in_instr[25:21];
    assign rt           = in_instr[20:16];
    assign rd           = in_instr[15:11];
    assign funct        = in_instr[5:0];
    assign imm          = in_instr[15:0];
    assign unused_shamt = ^in_instr[10:6];
    assign is_rtype     = (opcode == OP_RTYPE);
    assign dest         = is_rtype ? rd : rt;

    always_comb begin
        legal    = 1'b0;
        sign_ext = 1'b0;
        if (is_rtype) begin
            legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU: begin legal = 1'b1; sign_ext = 1'b1; end
                OP_ANDI, OP_ORI:   legal = 1'b1;
                default:           legal = 1'b0;
            endcase
        end
    end

    assign imm_ext = sign_ext ? {{(DATA_W-16){imm[15]}}, imm} : {{(DATA_W-16){1'b0}}, imm};

    // $0 reads as zero and is never pending regardless of scoreboard contents
    always_comb begin
        rs_val     = (rs == 5'd0) ? '0 : regfile[rs];
        rt_val     = (rt == 5'd0) ? '0 : regfile[rt];
        rs_pending = (rs != 5'd0) && scoreboard[rs];
        rt_pending = (rt != 5'd0) && scoreboard[rt];
`ifdef ALU_ISSUE_BYPASS_EN
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs)) begin
            rs_val     = wb_data;
            rs_pending = 1'b0;
        end
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rt)) begin
            rt_val     = wb_data;
            rt_pending = 1'b0;
        end
`endif
    end

    assign dest_pending = (dest != 5'd0) && scoreboard[dest];
    assign hazard       = rs_pending | (is_rtype & rt_pending) | dest_pending;
    assign in_ready     = (!out_valid | out_ready) & !hazard;
    assign accept       = in_valid & in_ready;

    // Clear is applied before set so a same-cycle issue to a retiring register stays pending
    assign wb_clear = (wb_en && (wb_addr != 5'd0)) ? (32'd1 << wb_addr) : 32'd0;
    assign sb_set   = (accept && legal && (dest != 5'd0)) ? (32'd1 << dest) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_control <= '0;
            out_src1    <= '0;
            out_src2    <= '0;
            out_dest    <= '0;
            illegal     <= 1'b0;
            stall_count <= '0;
            scoreboard  <= '0;
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end else begin
            illegal <= 1'b0;
            if (in_valid && !in_ready && (stall_count != '1))
                stall_count <= stall_count + STALL_CNT_W'(1);
            if (accept && legal) begin
                out_valid   <= 1'b1;
                out_control <= {opcode, is_rtype ? funct : 6'd0};
                out_src1    <= rs_val;
                out_src2    <= is_rtype ? rt_val : imm_ext;
                out_dest    <= dest;
            end else if (accept) begin
                out_valid <= 1'b0;
                illegal   <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (wb_en && (wb_addr != 5'd0)) regfile[wb_addr] <= wb_data;
            scoreboard <= (scoreboard & ~wb_clear) | sb_set;
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit (default build, ALU_ISSUE_BYPASS_EN undefined):
// directed scenarios with literal expectations followed by randomized traffic against a model.
module tb_alu_issue_unit;
    localparam int DATA_W = 32;
    localparam int SCW    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [11:0]       out_control;
    logic [DATA_W-1:0] out_src1, out_src2;
    logic [4:0]        out_dest;
    logic              wb_en = 1'b0;
    logic [4:0]        wb_addr = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              illegal;
    logic [SCW-1:0]    stall_count;

    always #5 clk = ~clk;

    alu_issue_unit #(.DATA_W(DATA_W), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_control(out_control),
        .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .stall_count(stall_count)
    );

    int checks = 0;
    int failures = 0;

    // Architectural model: register values, pending set, the bundle the ALU should see
    logic [31:0] mRegs [32];
    bit          mPend [32];
    bit          mValid, mIllegal;
    logic [11:0] mCtrl;
    logic [31:0] mSrc1, mSrc2;
    logic [4:0]  mDest;
    int unsigned mStall;
    int          wbQueue[$];
    bit          modelLive = 1'b0;

    typedef struct {
        bit          legal;
        bit          isR;
        logic [4:0]  rs, rt, dest;
        logic [11:0] ctrl;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(logic [31:0] w);
        dec_t d;
        logic [5:0] op, fn;
        op     = w[31:26];
        fn     = w[5:0];
        d.rs   = w[25:21];
        d.rt   = w[20:16];
        d.isR  = (op == 6'd0);
        d.dest = d.isR ? w[15:11] : w[20:16];
        d.ctrl = {op, d.isR ? fn : 6'd0};
        d.legal = 1'b0;
        d.imm   = '0;
        if (d.isR) d.legal = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        else if (op == 6'h08 || op == 6'h09) begin
            d.legal = 1'b1;
            d.imm   = {{16{w[15]}}, w[15:0]};
        end else if (op == 6'h0C || op == 6'h0D) begin
            d.legal = 1'b1;
            d.imm   = {16'h0, w[15:0]};
        end
        return d;
    endfunction

    function automatic bit busy(logic [4:0] r);
        return (r != 5'd0) && mPend[r];
    endfunction

    function automatic bit modelReady(logic [31:0] w, bit ordy);
        dec_t d;
        d = decode(w);
        return (!mValid || ordy) && !(busy(d.rs) || (d.isR && busy(d.rt)) || busy(d.dest));
    endfunction

    always @(posedge clk) begin : model_p
        dec_t d;
        bit   rdy;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mRegs[i] = '0;
                mPend[i] = 1'b0;
            end
            mValid = 0; mIllegal = 0; mCtrl = '0; mSrc1 = '0; mSrc2 = '0; mDest = '0;
            mStall = 0;
            wbQueue.delete();
            modelLive = 1'b1;
        end else begin
            d   = decode(in_instr);
            rdy = modelReady(in_instr, out_ready);
            mIllegal = 1'b0;
            if (in_valid && !rdy && mStall < 32'hFFFF) mStall++;
            if (in_valid && rdy) begin
                if (d.legal) begin
                    mValid = 1'b1;
                    mCtrl  = d.ctrl;
                    mSrc1  = mRegs[d.rs];
                    mSrc2  = d.isR ? mRegs[d.rt] : d.imm;
                    mDest  = d.dest;
                end else begin
                    mValid   = 1'b0;
                    mIllegal = 1'b1;
                end
            end else if (out_ready) begin
                mValid = 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) begin
                mRegs[wb_addr] = wb_data;
                mPend[wb_addr] = 1'b0;
            end
            if (in_valid && rdy && d.legal && d.dest != 5'd0) begin
                mPend[d.dest] = 1'b1;
                wbQueue.push_back(int'(d.dest));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("out_valid", 32'(out_valid), 32'(mValid));
            checkOutput("illegal", 32'(illegal), 32'(mIllegal));
            checkOutput("stall_count", 32'(stall_count), mStall);
            checkOutput("in_ready", 32'(in_ready), 32'(modelReady(in_instr, out_ready)));
            if (mValid) begin
                checkOutput("out_control", 32'(out_control), 32'(mCtrl));
                checkOutput("out_src1", out_src1, mSrc1);
                checkOutput("out_src2", out_src2, mSrc2);
                checkOutput("out_dest", 32'(out_dest), 32'(mDest));
            end
        end
    end

    task automatic applyStimulus(input bit r, input bit v, input logic [31:0] instr, input bit ordy,
                                 input bit wen, input logic [4:0] waddr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_instr = instr; out_ready = ordy;
        wb_en = wen; wb_addr = waddr; wb_data = wdata;
        #1;
    endtask

    function automatic logic [31:0] randInstr();
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        int k;
        k   = $urandom_range(0, 9);
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 4))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h2A;
        endcase
        if (k == 4) fn = 6'($urandom);
        case (k)
            5: op = 6'h08;
            6: op = 6'h09;
            7: op = 6'h0C;
            8: op = 6'h0D;
            9: op = 6'($urandom);
            default: op = 6'h00;
        endcase
        return (op == 6'h00) ? {op, rs, rt, rd, sh, fn} : {op, rs, rt, imm};
    endfunction

    localparam logic [31:0] ADDI1   = 32'h20010005;
    localparam logic [31:0] ADD211  = 32'h00211020;
    localparam logic [31:0] ORI3    = 32'h3403FFFF;
    localparam logic [31:0] ADDIU4  = 32'h2404FFFF;
    localparam logic [31:0] ORI5    = 32'h34050001;
    localparam logic [31:0] BADOP   = 32'hFC060000;
    localparam logic [31:0] ADDI76  = 32'h20C70001;

    initial begin
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_control", 32'(out_control), 0);
        checkOutput("rst_src1", out_src1, 0);
        checkOutput("rst_src2", out_src2, 0);
        checkOutput("rst_dest", 32'(out_dest), 0);
        checkOutput("rst_illegal", 32'(illegal), 0);
        checkOutput("rst_stall", 32'(stall_count), 0);

        // addi $1,$0,5 then add $2,$1,$1 blocked until $1 returns
        applyStimulus(0, 1, ADDI1, 1, 0, 0, 0);
        checkOutput("addi_ready", 32'(in_ready), 1);
        applyStimulus(0, 1, ADD211, 1, 0, 0, 0);
        checkOutput("addi_valid", 32'(out_valid), 1);
        checkOutput("addi_control", 32'(out_control), 32'h200);
        checkOutput("addi_src1", out_src1, 0);
        checkOutput("addi_src2", out_src2, 5);
        checkOutput("addi_dest", 32'(out_dest), 1);
        checkOutput("raw_blocked", 32'(in_ready), 0);
        applyStimulus(0, 1, ADD211, 1, 1, 5'd1, 32'd5);
        checkOutput("raw_stall1", 32'(stall_count), 1);
        checkOutput("raw_wb_cycle_blocked", 32'(in_ready), 0);
        applyStimulus(0, 1, ADD211, 1, 0, 0, 0);
        checkOutput("raw_stall2", 32'(stall_count), 2);
        checkOutput("raw_released", 32'(in_ready), 1);
        applyStimulus(0, 1, ORI3, 1, 0, 0, 0);
        checkOutput("add_control", 32'(out_control), 32'h020);
        checkOutput("add_src1", out_src1, 5);
        checkOutput("add_src2", out_src2, 5);
        checkOutput("add_dest", 32'(out_dest), 2);

        // Immediate extension: ori zero-extends, addiu sign-extends
        applyStimulus(0, 1, ADDIU4, 1, 0, 0, 0);
        checkOutput("ori_control", 32'(out_control), 32'h340);
        checkOutput("ori_src2", out_src2, 32'h0000FFFF);
        checkOutput("ori_dest", 32'(out_dest), 3);
        applyStimulus(0, 1, ORI5, 0, 0, 0, 0);
        checkOutput("addiu_control", 32'(out_control), 32'h240);
        checkOutput("addiu_src2", out_src2, 32'hFFFFFFFF);
        checkOutput("hold_blocked", 32'(in_ready), 0);

        // Backpressure: bundle must stay put while out_ready is low
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, ORI5, 0, 0, 0, 0);
            checkOutput("hold_valid", 32'(out_valid), 1);
            checkOutput("hold_src2", out_src2, 32'hFFFFFFFF);
            checkOutput("hold_dest", 32'(out_dest), 4);
        end
        applyStimulus(0, 1, ORI5, 1, 0, 0, 0);
        checkOutput("hold_release_ready", 32'(in_ready), 1);

        // Unsupported opcode with rt=6: dropped, flagged, $6 left clear
        applyStimulus(0, 1, BADOP, 1, 0, 0, 0);
        checkOutput("ori5_dest", 32'(out_dest), 5);
        checkOutput("ori5_src2", out_src2, 1);
        applyStimulus(0, 1, ADDI76, 1, 0, 0, 0);
        checkOutput("illegal_pulse", 32'(illegal), 1);
        checkOutput("illegal_no_issue", 32'(out_valid), 0);
        checkOutput("illegal_sb_clean", 32'(in_ready), 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("illegal_once", 32'(illegal), 0);
        checkOutput("addi7_dest", 32'(out_dest), 7);

        // Reset in the middle of a held transfer with $1 pending
        applyStimulus(0, 1, ADDI1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("pre_rst_valid", 32'(out_valid), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, ADD211, 1, 0, 0, 0);
        checkOutput("post_rst_valid", 32'(out_valid), 0);
        checkOutput("post_rst_stall", 32'(stall_count), 0);
        checkOutput("post_rst_ready", 32'(in_ready), 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("post_rst_add_src1", out_src1, 0);
        checkOutput("post_rst_add_dest", 32'(out_dest), 2);

        // Randomized traffic; writebacks return for outstanding destinations in random order
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit          wen;
            logic [4:0]  wa;
            int          idx;
            @(posedge clk);
            #1;
            wen = 1'b0;
            wa  = '0;
            if (wbQueue.size() > 0 && $urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, wbQueue.size() - 1);
                wa  = 5'(wbQueue[idx]);
                wbQueue.delete(idx);
                wen = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                wen = 1'b1;
            end
            rst       = ($urandom_range(0, 499) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = randInstr();
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = wen;
            wb_addr   = wa;
            wb_data   = $urandom;
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
